gate_direction_decoder: RTL and testbench
=========================================

GATE_DIRECTION_DECODER -- requirements
Module: gate_direction_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before a beam change is accepted; legal range 1 to 2^24-1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000000: cycles without a state change, in a non-IDLE and non-FAULT state, before the FSM enters FAULT; legal range 1 to 2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all flops on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port beamA, input, 1 bit: outer photo-beam, asynchronous, 1 = blocked.
REQ-006 SHALL have port beamB, input, 1 bit: inner photo-beam, asynchronous, 1 = blocked.
REQ-007 SHALL have port carEntry, output, 1 bit: one-cycle pulse per completed inward passage; feeds the parking counter entry input.
REQ-008 SHALL have port carExit, output, 1 bit: one-cycle pulse per completed outward passage; feeds the parking counter exit input.
REQ-009 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.
REQ-010 SHALL have port fault, output, 1 bit: high while the FSM is in FAULT.
REQ-011 SHALL have port gateState, output, 3 bits: current FSM state encoding.

Function
REQ-012 SHALL pass each beam through a 2-flop synchronizer and then a per-beam stability filter.
REQ-013 Each filter SHALL update its filtered value only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch SHALL restart the count.
REQ-014 The FSM SHALL use states IDLE=0, ENT1=1, ENT2=2, ENT3=3, EXT1=4, EXT2=5, EXT3=6, FAULT=7, with {A,B} denoting the filtered beams.
REQ-015 From IDLE: 10 goes to ENT1; 01 goes to EXT1; 11 goes to FAULT; 00 holds.
REQ-016 From ENT1: 11 goes to ENT2; 00 goes to IDLE with no pulse; 01 goes to FAULT.
REQ-017 From ENT2: 01 goes to ENT3; 10 goes to ENT1; 00 goes to FAULT.
REQ-018 From ENT3: 00 goes to IDLE and asserts carEntry; 11 goes to ENT2; 10 goes to FAULT.
REQ-019 EXT1, EXT2 and EXT3 SHALL mirror ENT1, ENT2 and ENT3 with A and B swapped; EXT3 on 00 goes to IDLE and asserts carExit.
REQ-020 FAULT SHALL hold until the filtered beams are 00, then go to IDLE with no pulse.
REQ-021 A timeout counter SHALL clear on every state change and while in IDLE or FAULT; at count == TIMEOUT_CYCLES the FSM SHALL go to FAULT.
REQ-022 A timeout and a legal beam transition on the same cycle SHALL resolve in favour of the beam transition.
REQ-023 carEntry and carExit SHALL be registered, asserted for exactly one cycle coincident with the IDLE return, and never asserted together.
REQ-024 Latency from a raw beam edge to the filtered change SHALL be 2+DEBOUNCE_CYCLES cycles; the state and pulse change SHALL follow 1 cycle later.
REQ-025 A car reversing mid-gate (e.g. ENT2 back to ENT1 back to IDLE) SHALL produce no pulse.

Reset
REQ-026 Reset SHALL immediately clear the synchronizers, filters (to 0), counters and pulse outputs, and force IDLE.
REQ-027 After reset, busy, fault, carEntry and carExit SHALL be 0 and gateState SHALL be 0.
REQ-028 Reset asserted mid-passage SHALL abandon the passage with no pulse; a beam held blocked through reset release SHALL be seen as a new change after filtering.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-029 Beams 00,10,11,01,00, each held 10 cycles -> exactly one carEntry pulse, 7 cycles after the final edge; no carExit.
REQ-030 Beams 00,01,11,10,00, each held 10 cycles -> exactly one carExit pulse; gateState steps through 4,5,6,0.
REQ-031 Beams 10,11,10,00 (reversal) -> no pulse; gateState steps through 1,2,1,0; busy falls with the IDLE return.
REQ-032 Beam A pulsed high for 3 cycles, repeated, from IDLE -> filter never changes, gateState stays 0.
REQ-033 Beam A held blocked for 60 cycles -> fault=1, gateState=7 after 50 cycles in ENT1; A released -> IDLE, no pulse.
REQ-034 Reset asserted while in ENT3 -> gateState 0 at once; no carEntry on the subsequent 00.

Source files
------------

// File: rtl/gate_direction_decoder_if.sv
// Purpose: bundles the gate's beam inputs and its decoded outputs into one port.
// Latency: none; this is only a set of wires.
// Backpressure: none; the beams are free-running and the outputs are pulses or levels.
// Ports:
//   beamA, beamB : raw photo-beam levels (1 = blocked), asynchronous to clk
//   carEntry     : one-cycle pulse per completed inward passage
//   carExit      : one-cycle pulse per completed outward passage
//   busy, fault  : FSM is not IDLE / FSM is in FAULT
//   gateState    : current FSM state encoding
interface gate_direction_decoder_if;
  logic       beamA;
  logic       beamB;
  logic       carEntry;
  logic       carExit;
  logic       busy;
  logic       fault;
  logic [2:0] gateState;

  // The master side drives the beams; the decoder consumes them and drives the status.
  modport master (
    output beamA, beamB,
    input  carEntry, carExit, busy, fault, gateState
  );

  modport slave (
    input  beamA, beamB,
    output carEntry, carExit, busy, fault, gateState
  );
endinterface

// File: rtl/gate_direction_decoder.sv
// Purpose: decodes two photo-beams into car entry/exit pulses with a direction FSM.
// Latency: raw beam edge -> filtered beam 2+DEBOUNCE_CYCLES cycles; state/pulse 1 cycle later.
// Backpressure: none; pulses are fire-and-forget, a stalled passage times out into FAULT.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   gate  : slave side of gate_direction_decoder_if (beams in, pulses/status out)
module gate_direction_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 200000000
) (
  input logic                     clk,
  input logic                     reset,
  gate_direction_decoder_if.slave gate
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENT1  = 3'd1,
    S_ENT2  = 3'd2,
    S_ENT3  = 3'd3,
    S_EXT1  = 3'd4,
    S_EXT2  = 3'd5,
    S_EXT3  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  // Bit 1 carries beam A, bit 0 carries beam B, so r_filt reads directly as {A,B}.
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_filt;
  logic [23:0] r_db_cnt [2];

  state_t      r_state;
  state_t      w_next;
  logic        w_entry;
  logic        w_exit;
  logic        w_timeout;
  logic        r_car_entry;
  logic        r_car_exit;
  logic [31:0] r_to_cnt;

  // Two-flop synchronizer followed by a per-beam stability filter. The counter
  // only runs while the synchronized level disagrees with the filtered level, so
  // a single cycle of agreement (a glitch back) throws away the partial count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 2'b00;
      r_sync2     <= 2'b00;
      r_filt      <= 2'b00;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= {gate.beamA, gate.beamB};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign w_timeout = (r_to_cnt == TO_LIMIT);

  // Next-state and pulse decode. Beam rules are evaluated first; the timeout only
  // applies when the beams did not already move the FSM, so a legal transition
  // arriving on the timeout cycle wins.
  always_comb begin
    w_next  = r_state;
    w_entry = 1'b0;
    w_exit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        case (r_filt)
          2'b10:   w_next = S_ENT1;
          2'b01:   w_next = S_EXT1;
          2'b11:   w_next = S_FAULT;
          default: w_next = S_IDLE;
        endcase
      end
      S_ENT1: begin
        case (r_filt)
          2'b11:   w_next = S_ENT2;
          2'b00:   w_next = S_IDLE;
          2'b01:   w_next = S_FAULT;
          default: w_next = S_ENT1;
        endcase
      end
      S_ENT2: begin
        case (r_filt)
          2'b01:   w_next = S_ENT3;
          2'b10:   w_next = S_ENT1;
          2'b00:   w_next = S_FAULT;
          default: w_next = S_ENT2;
        endcase
      end
      S_ENT3: begin
        case (r_filt)
          2'b00: begin
            w_next  = S_IDLE;
            w_entry = 1'b1;
          end
          2'b11:   w_next = S_ENT2;
          2'b10:   w_next = S_FAULT;
          default: w_next = S_ENT3;
        endcase
      end
      // Exit states are the entry states with the roles of A and B swapped.
      S_EXT1: begin
        case (r_filt)
          2'b11:   w_next = S_EXT2;
          2'b00:   w_next = S_IDLE;
          2'b10:   w_next = S_FAULT;
          default: w_next = S_EXT1;
        endcase
      end
      S_EXT2: begin
        case (r_filt)
          2'b10:   w_next = S_EXT3;
          2'b01:   w_next = S_EXT1;
          2'b00:   w_next = S_FAULT;
          default: w_next = S_EXT2;
        endcase
      end
      S_EXT3: begin
        case (r_filt)
          2'b00: begin
            w_next = S_IDLE;
            w_exit = 1'b1;
          end
          2'b11:   w_next = S_EXT2;
          2'b01:   w_next = S_FAULT;
          default: w_next = S_EXT3;
        endcase
      end
      default: begin
        // FAULT waits for both beams clear before re-arming.
        if (r_filt == 2'b00) begin
          w_next = S_IDLE;
        end
      end
    endcase

    if ((w_next == r_state) && w_timeout &&
        (r_state != S_IDLE) && (r_state != S_FAULT)) begin
      w_next = S_FAULT;
    end
  end

  // State, timeout counter and registered pulses. The pulses are registered on the
  // same edge that returns the FSM to IDLE, so they line up with that return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_car_entry <= 1'b0;
      r_car_exit  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_car_entry <= w_entry;
      r_car_exit  <= w_exit;
      if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_FAULT)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
    end
  end

  assign gate.carEntry  = r_car_entry;
  assign gate.carExit   = r_car_exit;
  assign gate.busy      = (r_state != S_IDLE);
  assign gate.fault     = (r_state == S_FAULT);
  assign gate.gateState = r_state;

endmodule

// File: tb/tb_gate_direction_decoder.sv
// Purpose: randomized scoreboard bench for gate_direction_decoder against a table-driven model.
// Latency: events are expected on the exact cycle predicted by the model.
// Backpressure: none; the monitor consumes every state change or pulse as it appears.
module tb_gate_direction_decoder;
  localparam int DEB = 4;
  localparam int TO  = 50;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  gate_direction_decoder_if gif ();

  gate_direction_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .gate (gif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [2:0] st;
    bit       en;
    bit       ex;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int mon_cyc  = 0;
  int n_entry  = 0;
  int n_exit   = 0;
  int last_entry_cyc = -1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transition table indexed by [state][{A,B}], plus an age counter for the stall timeout.
  int       trans [8][4];
  int       m_state;
  int       m_age;
  int       m_n = 0;
  bit [1:0] pa, pb;        // two-cycle delay of each raw beam
  bit       fa, fb;        // filtered beams
  bit       ra_val, rb_val;
  int       ra_len, rb_len;

  function automatic void model_reset();
    m_state = 0;
    m_age   = 0;
    pa = 2'b00; pb = 2'b00;
    fa = 1'b0;  fb = 1'b0;
    ra_val = 1'b0; rb_val = 1'b0;
    ra_len = 0;    rb_len = 0;
  endfunction

  // A delayed level is accepted once it has been seen DEB cycles in a row.
  function automatic void run_upd(input bit d, inout bit val, inout int len, inout bit filt);
    if (d == val) len++;
    else begin
      val = d;
      len = 1;
    end
    if (val != filt && len >= DEB) filt = val;
  endfunction

  function automatic void model_step(input bit a, input bit b);
    bit  da, db;
    int  nxt;
    ev_t e;
    da = pa[1]; pa = {pa[0], a};
    db = pb[1]; pb = {pb[0], b};
    nxt = trans[m_state][fa * 2 + fb];
    if (nxt == m_state && m_state != 0 && m_state != 7 && m_age == TO) nxt = 7;
    if (nxt != m_state) begin
      e.cyc = m_n;
      e.st  = 3'(nxt);
      e.en  = (m_state == 3 && nxt == 0);
      e.ex  = (m_state == 6 && nxt == 0);
      exp_q.push_back(e);
    end
    m_age   = (nxt != m_state || m_state == 0 || m_state == 7) ? 0 : m_age + 1;
    m_state = nxt;
    run_upd(da, ra_val, ra_len, fa);
    run_upd(db, rb_val, rb_len, fb);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc1(input bit a, input bit b);
    gif.beamA = a;
    gif.beamB = b;
    @(posedge clk);
    m_n++;
    if (reset) model_reset();
    else model_step(a, b);
    @(negedge clk);
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    repeat (n) cyc1(a, b);
  endtask

  task automatic do_reset(input bit a, input bit b, input int n);
    #1 reset = 1'b1;
    #1;
    check("reset_state_at_once", gif.gateState, 0);
    check("reset_entry_at_once", gif.carEntry, 0);
    hold(a, b, n);
    reset = 1'b0;
  endtask

  task automatic walk(input bit dir_out, input int len);
    if (!dir_out) begin
      hold(1, 0, len); hold(1, 1, len); hold(0, 1, len); hold(0, 0, len);
    end else begin
      hold(0, 1, len); hold(1, 1, len); hold(1, 0, len); hold(0, 0, len);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (reset) begin
      prev_state = 3'd0;
    end else if (gif.gateState !== prev_state || gif.carEntry !== 1'b0 || gif.carExit !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: cycle %0d state %0d entry %0b exit %0b, none expected",
                 mon_cyc, gif.gateState, gif.carEntry, gif.carExit);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", mon_cyc, e.cyc);
        check("event_state_entry_exit_busy_fault",
              {gif.gateState, gif.carEntry, gif.carExit, gif.busy, gif.fault},
              {e.st, e.en, e.ex, (e.st != 3'd0), (e.st == 3'd7)});
      end
      if (gif.carEntry === 1'b1) begin
        n_entry++;
        last_entry_cyc = mon_cyc;
      end
      if (gif.carExit === 1'b1) n_exit++;
      prev_state = gif.gateState;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int e0, x0, edge_cyc;
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 4; k++) trans[s][k] = s;
    trans[0][2] = 1; trans[0][1] = 4; trans[0][3] = 7;
    trans[1][3] = 2; trans[1][0] = 0; trans[1][1] = 7;
    trans[2][1] = 3; trans[2][2] = 1; trans[2][0] = 7;
    trans[3][0] = 0; trans[3][3] = 2; trans[3][2] = 7;
    trans[4][3] = 5; trans[4][0] = 0; trans[4][2] = 7;
    trans[5][2] = 6; trans[5][1] = 4; trans[5][0] = 7;
    trans[6][0] = 0; trans[6][3] = 5; trans[6][1] = 7;
    trans[7][0] = 0;
    model_reset();
    gif.beamA = 1'b0;
    gif.beamB = 1'b0;

    hold(0, 0, 3);
    reset = 1'b0;
    hold(0, 0, 2);
    check("reset_busy", gif.busy, 0);
    check("reset_fault", gif.fault, 0);
    check("reset_entry", gif.carEntry, 0);
    check("reset_exit", gif.carExit, 0);
    check("reset_state", gif.gateState, 0);

    // Inward passage: one entry pulse, 7 cycles after the final edge.
    e0 = n_entry; x0 = n_exit;
    hold(0, 0, 10); hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    edge_cyc = m_n;
    hold(0, 0, 10);
    check("entry_latency", last_entry_cyc - edge_cyc, 7);
    check("entry_count", n_entry - e0, 1);
    check("entry_no_exit", n_exit - x0, 0);

    // Outward passage.
    e0 = n_entry; x0 = n_exit;
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check("exit_count", n_exit - x0, 1);
    check("exit_no_entry", n_entry - e0, 0);

    // Reversal mid-gate.
    e0 = n_entry; x0 = n_exit;
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check("reversal_no_pulse", (n_entry - e0) + (n_exit - x0), 0);
    check("reversal_busy_end", gif.busy, 0);

    // Short glitches never pass the filter.
    repeat (5) begin hold(1, 0, 3); hold(0, 0, 3); end
    check("glitch_state", gif.gateState, 0);

    // Stall in ENT1 times out to FAULT; release returns to IDLE.
    e0 = n_entry; x0 = n_exit;
    hold(1, 0, 60);
    check("timeout_fault", gif.fault, 1);
    check("timeout_state", gif.gateState, 7);
    hold(0, 0, 10);
    check("fault_release_state", gif.gateState, 0);
    check("fault_release_no_pulse", (n_entry - e0) + (n_exit - x0), 0);

    // Reset in ENT3 abandons the passage.
    e0 = n_entry;
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    check("reach_ent3", gif.gateState, 3);
    do_reset(0, 1, 2);
    hold(0, 0, 12);
    check("reset_ent3_no_entry", n_entry - e0, 0);

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) walk(1'($urandom_range(0, 1)), $urandom_range(5, 12));
      else if (r == 3) hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(55, 70));
      else if (r == 4) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(2, 4));
      else hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end

    hold(0, 0, 80);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_state_idle", gif.gateState, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
